// File: rtl/alu_pkg.sv
// Shared widths and operation encodings for the execute-stage ALU.
package alu_pkg;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    // Group select encodings
    localparam logic [2:0] GRP_ARITH = 3'b000;
    localparam logic [2:0] GRP_LOGIC = 3'b011;
    localparam logic [2:0] GRP_SHIFT = 3'b111;

    // Arithmetic sub-ops
    localparam logic [2:0] ADD  = 3'b000;
    localparam logic [2:0] SUB  = 3'b001;
    localparam logic [2:0] INCA = 3'b010;
    localparam logic [2:0] INCB = 3'b011;
    localparam logic [2:0] DECA = 3'b100;
    localparam logic [2:0] DECB = 3'b101;
    localparam logic [2:0] GT   = 3'b110;
    localparam logic [2:0] LT   = 3'b111;

    // Logic sub-ops
    localparam logic [2:0] AND  = 3'b000;
    localparam logic [2:0] OR   = 3'b001;
    localparam logic [2:0] NOR  = 3'b010;
    localparam logic [2:0] XOR  = 3'b011;
    localparam logic [2:0] XNOR = 3'b100;
    localparam logic [2:0] NOTA = 3'b101;
    localparam logic [2:0] NOTB = 3'b110;
    localparam logic [2:0] NAND = 3'b111;

    // Shift sub-ops (100..111 are unused and produce zero)
    localparam logic [2:0] SLA   = 3'b000;
    localparam logic [2:0] SRA_L = 3'b001;
    localparam logic [2:0] SLB   = 3'b010;
    localparam logic [2:0] SRB   = 3'b011;

endpackage

// File: rtl/alu_if.sv
// Operand / select / result bundle between the issuing stage and the ALU.
interface alu_if;
    import alu_pkg::*;

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] in;
    logic             load_en;
    logic [2:0]       sel;
    logic [2:0]       sel1;
    logic [2:0]       sel2;
    logic [2:0]       sel3;
    logic [SHW-1:0]   shift;
    logic [WIDTH-1:0] result;

    modport master (
        output a, b, in, load_en, sel, sel1, sel2, sel3, shift,
        input  result
    );

    modport slave (
        input  a, b, in, load_en, sel, sel1, sel2, sel3, shift,
        output result
    );
endinterface

// File: rtl/alu_core.sv
// Purely combinational ALU function; the caller supplies the effective A.
module alu_core
    import alu_pkg::*;
(
    input  logic [WIDTH-1:0] ea,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    input  logic [2:0]       sel1,
    input  logic [2:0]       sel2,
    input  logic [2:0]       sel3,
    input  logic [SHW-1:0]   shift,
    output logic [WIDTH-1:0] next_result
);

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = '0;

    // Select the group, then the op within it; anything unassigned yields zero
    always_comb begin
        next_result = ZERO;
        unique case (sel)
            GRP_ARITH: begin
                unique case (sel1)
                    ADD:  next_result = ea + b;
                    SUB:  next_result = ea - b;
                    INCA: next_result = ea + ONE;
                    INCB: next_result = b + ONE;
                    DECA: next_result = ea - ONE;
                    DECB: next_result = b - ONE;
                    GT:   next_result = (ea > b) ? ONE : ZERO;
                    LT:   next_result = (ea < b) ? ONE : ZERO;
                    default: next_result = ZERO;
                endcase
            end
            GRP_LOGIC: begin
                unique case (sel2)
                    AND:  next_result = ea & b;
                    OR:   next_result = ea | b;
                    NOR:  next_result = ~(ea | b);
                    XOR:  next_result = ea ^ b;
                    XNOR: next_result = ~(ea ^ b);
                    NOTA: next_result = ~ea;
                    NOTB: next_result = ~b;
                    NAND: next_result = ~(ea & b);
                    default: next_result = ZERO;
                endcase
            end
            GRP_SHIFT: begin
                case (sel3)
                    SLA:   next_result = ea << shift;
                    SRA_L: next_result = ea >> shift;
                    SLB:   next_result = b << shift;
                    SRB:   next_result = b >> shift;
                    default: next_result = ZERO;
                endcase
            end
            default: next_result = ZERO;
        endcase
    end

endmodule

// File: rtl/alu.sv
// Execute-stage ALU: operand A mux, combinational core, registered result.
module alu
    import alu_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    alu_if.slave  bus
);

    logic [WIDTH-1:0] ea;
    logic [WIDTH-1:0] next_result;
    logic [WIDTH-1:0] result_q;

    // Load path replaces operand A for every operation class
    always_comb begin
        ea = bus.load_en ? bus.in : bus.a;
    end

    alu_core u_core (
        .ea          (ea),
        .b           (bus.b),
        .sel         (bus.sel),
        .sel1        (bus.sel1),
        .sel2        (bus.sel2),
        .sel3        (bus.sel3),
        .shift       (bus.shift),
        .next_result (next_result)
    );

    // Result register; reset wins over any operation
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
        end else begin
            result_q <= next_result;
        end
    end

    assign bus.result = result_q;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the ALU with hand-computed expected results.
module tb_alu;
    import alu_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;

    alu_if bus ();

    alu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Apply one operation, clock it and check the registered result
    task automatic run(input string tag, input logic ld, input logic [31:0] av,
                       input logic [31:0] bv, input logic [31:0] inv,
                       input logic [2:0] s, input logic [2:0] s1,
                       input logic [2:0] s2, input logic [2:0] s3,
                       input logic [4:0] sh, input logic [31:0] exp);
        bus.load_en = ld;
        bus.a       = av;
        bus.b       = bv;
        bus.in      = inv;
        bus.sel     = s;
        bus.sel1    = s1;
        bus.sel2    = s2;
        bus.sel3    = s3;
        bus.shift   = sh;
        step();
        check(tag, bus.result, exp);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst         = 1'b1;
        bus.a       = 32'd10;
        bus.b       = 32'd20;
        bus.in      = 32'd0;
        bus.load_en = 1'b0;
        bus.sel     = GRP_ARITH;
        bus.sel1    = ADD;
        bus.sel2    = 3'd0;
        bus.sel3    = 3'd0;
        bus.shift   = 5'd0;

        step();
        check("reset_c1", bus.result, 32'h0);
        step();
        check("reset_c2", bus.result, 32'h0);
        rst = 1'b0;

        // Arithmetic; inactive sub-selects set to non-zero junk
        run("add",  0, 10, 20, 0, 3'b000, 3'b000, 3'b111, 3'b010, 5'd3, 32'd30);
        run("sub",  0, 10, 20, 0, 3'b000, 3'b001, 3'b101, 3'b001, 5'd3, 32'hFFFF_FFF6);
        run("inca", 0, 10, 20, 0, 3'b000, 3'b010, 3'b001, 3'b011, 5'd3, 32'd11);
        run("incb", 0, 10, 20, 0, 3'b000, 3'b011, 3'b010, 3'b000, 5'd3, 32'd21);
        run("deca", 0, 10, 20, 0, 3'b000, 3'b100, 3'b011, 3'b000, 5'd3, 32'd9);
        run("decb", 0, 10, 20, 0, 3'b000, 3'b101, 3'b100, 3'b001, 5'd3, 32'd19);
        run("gt",   0, 10, 20, 0, 3'b000, 3'b110, 3'b110, 3'b010, 5'd3, 32'd0);
        run("lt",   0, 10, 20, 0, 3'b000, 3'b111, 3'b111, 3'b011, 5'd3, 32'd1);
        run("gt_true", 0, 20, 10, 0, 3'b000, 3'b110, 3'b000, 3'b000, 5'd0, 32'd1);

        // Logic
        run("and",  0, 10, 20, 0, 3'b011, 3'b001, 3'b000, 3'b001, 5'd0, 32'd0);
        run("or",   0, 10, 20, 0, 3'b011, 3'b010, 3'b001, 3'b010, 5'd0, 32'd30);
        run("nor",  0, 10, 20, 0, 3'b011, 3'b011, 3'b010, 3'b011, 5'd0, 32'hFFFF_FFE1);
        run("xor",  0, 10, 20, 0, 3'b011, 3'b100, 3'b011, 3'b000, 5'd0, 32'd30);
        run("xnor", 0, 10, 20, 0, 3'b011, 3'b101, 3'b100, 3'b001, 5'd0, 32'hFFFF_FFE1);
        run("nota", 0, 10, 20, 0, 3'b011, 3'b110, 3'b101, 3'b010, 5'd0, 32'hFFFF_FFF5);
        run("notb", 0, 10, 20, 0, 3'b011, 3'b111, 3'b110, 3'b011, 5'd0, 32'hFFFF_FFEB);
        run("nand", 0, 10, 20, 0, 3'b011, 3'b000, 3'b111, 3'b000, 5'd0, 32'hFFFF_FFFF);
        run("xor_ovl", 0, 32'hF0F0_1234, 32'h0FF0_FFFF, 0, 3'b011, 3'b000, 3'b011, 3'b000, 5'd0, 32'hFF00_EDCB);

        // Shift
        run("sla",  0, 10, 20, 0, 3'b111, 3'b000, 3'b101, 3'b000, 5'd2, 32'd40);
        run("srl_a",0, 10, 20, 0, 3'b111, 3'b001, 3'b101, 3'b001, 5'd2, 32'd2);
        run("slb",  0, 10, 20, 0, 3'b111, 3'b010, 3'b101, 3'b010, 5'd2, 32'd80);
        run("srb",  0, 10, 20, 0, 3'b111, 3'b011, 3'b101, 3'b011, 5'd2, 32'd5);
        run("sh100",0, 10, 20, 0, 3'b111, 3'b000, 3'b000, 3'b100, 5'd2, 32'd0);
        run("sh111",0, 10, 20, 0, 3'b111, 3'b000, 3'b000, 3'b111, 5'd2, 32'd0);
        run("sla31",0, 1,  20, 0, 3'b111, 3'b000, 3'b000, 3'b000, 5'd31, 32'h8000_0000);
        run("srl31",0, 32'h8000_0000, 20, 0, 3'b111, 3'b000, 3'b000, 3'b001, 5'd31, 32'd1);
        run("sh0",  0, 32'hDEAD_BEEF, 20, 0, 3'b111, 3'b000, 3'b000, 3'b001, 5'd0, 32'hDEAD_BEEF);
        run("srl_a_zf", 0, 32'h8000_0000, 20, 0, 3'b111, 3'b000, 3'b000, 3'b001, 5'd4, 32'h0800_0000);

        // Load path
        run("ld_inca", 1, 10, 20, 100, 3'b000, 3'b010, 3'b000, 3'b000, 5'd0, 32'd101);
        run("ld_add",  1, 10, 20, 100, 3'b000, 3'b000, 3'b000, 3'b000, 5'd0, 32'd120);
        run("ld_nota", 1, 10, 20, 100, 3'b011, 3'b000, 3'b101, 3'b000, 5'd0, 32'hFFFF_FF9B);
        run("ld_sla",  1, 10, 20, 100, 3'b111, 3'b000, 3'b000, 3'b000, 5'd1, 32'd200);

        // Boundaries
        run("wrap_inc", 0, 32'hFFFF_FFFF, 20, 0, 3'b000, 3'b010, 3'b000, 3'b000, 5'd0, 32'd0);
        run("wrap_dec", 0, 32'd0, 20, 0, 3'b000, 3'b100, 3'b000, 3'b000, 5'd0, 32'hFFFF_FFFF);
        run("wrap_incb",0, 10, 32'hFFFF_FFFF, 0, 3'b000, 3'b011, 3'b000, 3'b000, 5'd0, 32'd0);
        run("wrap_sub", 0, 32'd0, 32'd1, 0, 3'b000, 3'b001, 3'b000, 3'b000, 5'd0, 32'hFFFF_FFFF);
        run("eq_gt",    0, 7, 7, 0, 3'b000, 3'b110, 3'b000, 3'b000, 5'd0, 32'd0);
        run("eq_lt",    0, 7, 7, 0, 3'b000, 3'b111, 3'b000, 3'b000, 5'd0, 32'd0);
        run("gt_msb",   0, 32'h8000_0000, 32'h7FFF_FFFF, 0, 3'b000, 3'b110, 3'b000, 3'b000, 5'd0, 32'd1);
        run("sel001",   0, 10, 20, 0, 3'b001, 3'b000, 3'b001, 3'b000, 5'd0, 32'd0);
        run("sel010",   0, 10, 20, 0, 3'b010, 3'b000, 3'b001, 3'b000, 5'd0, 32'd0);
        run("sel100",   0, 10, 20, 0, 3'b100, 3'b000, 3'b001, 3'b000, 5'd0, 32'd0);
        run("sel101",   0, 10, 20, 0, 3'b101, 3'b000, 3'b001, 3'b000, 5'd0, 32'd0);
        run("sel110",   0, 10, 20, 0, 3'b110, 3'b000, 3'b001, 3'b000, 5'd0, 32'd0);

        // Reset in the middle of a steady ADD stream
        run("pre_rst", 0, 10, 20, 0, 3'b000, 3'b000, 3'b000, 3'b000, 5'd0, 32'd30);
        rst = 1'b1;
        step();
        check("mid_rst", bus.result, 32'd0);
        rst = 1'b0;
        step();
        check("post_rst", bus.result, 32'd30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 32-bit combinational-datapath ALU with a registered output.
- Performs arithmetic, logic and shift operations on two unsigned operands.
- A top-level group select chooses the operation class; a per-class sub-select chooses the operation.
- An optional load path substitutes an external input word for operand A. Sits as the execute-stage datapath element; the result is held in an output register.

Parameters:
- WIDTH, 32, data width of operands, input word and result.
- SHW, 5, width of the shift-amount port (log2 of WIDTH).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- in  input  WIDTH  alternate operand A, used when load_en=1.
- load_en  input  1  1: effective A = in; 0: effective A = a.
- sel  input  3  operation group: 000 arithmetic, 011 logic, 111 shift.
- sel1  input  3  arithmetic sub-select.
- sel2  input  3  logic sub-select.
- sel3  input  3  shift sub-select.
- shift  input  SHW  shift amount, 0..31.
- result  output  WIDTH  registered result.

Behaviour:
- Effective A: EA = load_en ? in : a. EA replaces A in every operation, including logic and shift. B is always b.
- result updates on every rising clk edge with f(inputs sampled that edge). Latency is 1 cycle. There is no enable and no handshake.
- rst=1 at an edge: result <= 0, overriding any operation. This includes reset asserted mid-sequence. The first valid result appears on the edge after rst deasserts.
- All arithmetic is unsigned and modulo 2^WIDTH. Carry and borrow are discarded, and there are no flag outputs.
- sel=000 (sel1):
  - 000 EA+b
  - 001 EA-b
  - 010 EA+1
  - 011 b+1
  - 100 EA-1
  - 101 b-1
  - 110 (EA>b) ? 1 : 0
  - 111 (EA<b) ? 1 : 0
  - Comparisons are unsigned, and equality yields 0 for both.
- sel=011 (sel2):
  - 000 EA&b
  - 001 EA|b
  - 010 ~(EA|b)
  - 011 EA^b
  - 100 ~(EA^b)
  - 101 ~EA
  - 110 ~b
  - 111 ~(EA&b) (NAND)
- sel=111 (sel3):
  - 000 EA<<shift
  - 001 EA>>shift
  - 010 b<<shift
  - 011 b>>shift
  - Shifts are logical and zero-fill; shift=0 passes the operand through.
  - sel3 100..111: next result = 0.
- Any other sel value (001, 010, 100, 101, 110): next result = 0.
- Sub-selects of inactive groups are ignored.
- Wrap-around examples:
  - 0xFFFFFFFF+1 = 0
  - 0-1 = 0xFFFFFFFF
  - b+1 with b=0xFFFFFFFF = 0

Decomposition:
- Package alu_pkg holds:
  - Group encodings: GRP_ARITH=3'b000, GRP_LOGIC=3'b011, GRP_SHIFT=3'b111.
  - Sub-op localparams for each group: ADD, SUB, INCA, INCB, DECA, DECB, GT, LT; AND, OR, NOR, XOR, XNOR, NOTA, NOTB, NAND; SLA, SRA_L, SLB, SRB.
- One natural sub-module, alu_core: a purely combinational function of (EA, b, sel*, shift) producing next_result. The top handles the operand mux and the output register with synchronous reset.

Test Plan:
- Reset and arithmetic: rst=1 for 2 cycles -> result=0. Then rst=0, a=10, b=20, load_en=0, sel=000, one cycle each:
  - sel1=000 -> 30
  - sel1=001 -> 0xFFFFFFF6
  - sel1=010 -> 11
  - sel1=011 -> 21
  - sel1=100 -> 9
  - sel1=101 -> 19
  - sel1=110 -> 0
  - sel1=111 -> 1
- Logic: a=10, b=20, sel=011:
  - sel2=000 -> 0
  - sel2=001 -> 30
  - sel2=010 -> 0xFFFFFFE1
  - sel2=011 -> 30
  - sel2=100 -> 0xFFFFFFE1
  - sel2=101 -> 0xFFFFFFF5
  - sel2=110 -> 0xFFFFFFEB
  - sel2=111 -> 0xFFFFFFFF
- Shift: a=10, b=20, shift=2, sel=111:
  - sel3=000 -> 40
  - sel3=001 -> 2
  - sel3=010 -> 80
  - sel3=011 -> 5
  - sel3=100 -> 0
  - shift=31, sel3=000, a=1 -> 0x80000000
- Load path: in=100, load_en=1, sel=000:
  - sel1=010 -> 101
  - sel1=000 with b=20 -> 120
  - sel=011, sel2=101 -> 0xFFFFFF9B
- Boundaries:
  - a=0xFFFFFFFF, sel1=010 -> 0
  - a=0, sel1=100 -> 0xFFFFFFFF
  - a=b=7, sel1=110 and 111 -> 0
  - sel=001 -> 0
- Reset mid-operation: steady ADD producing 30, assert rst for one edge -> 0 that cycle, 30 again on the edge after release.
